// File: rtl/sp_ram_pkg.sv
// Shared definitions for the parametrised single-port RAM: read-during-write
// mode codes, controller state encoding and the byte parity helper.
package sp_ram_pkg;

  localparam int RD_FIRST  = 0;
  localparam int WR_FIRST  = 1;
  localparam int NO_CHANGE = 2;

  localparam int BYTE_W = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Even parity: the stored bit makes the 9-bit lane have an even number of ones.
  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sp_ram_core.sv
// Bare storage array for param_sp_ram: lane-granular write enables and a
// registered read port. The read register captures the pre-write contents
// when a write hits the same address (read-first at the array level); the
// controller derives the other read-during-write behaviours from that.
// The array has no reset; contents are defined by the controller's clear sweep.
module sp_ram_core #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      i_en,
  input  logic                      i_we,
  input  logic [LANES-1:0]          i_be,
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic [LANES*LANE_W-1:0]   i_wdata,
  output logic [LANES*LANE_W-1:0]   o_rdata
);

  logic [LANES*LANE_W-1:0] r_mem [DEPTH];

  // Registered read of the old word plus lane-masked write on enable.
  always_ff @(posedge clk) begin
    if (i_en) begin
      o_rdata <= r_mem[i_addr];
      if (i_we) begin
        for (int i = 0; i < LANES; i++) begin
          if (i_be[i]) begin
            r_mem[i_addr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/param_sp_ram.sv
// Parametrised single-port RAM with valid/ready request handshake, per-byte
// write enables, selectable read-during-write response and a zero-fill clear
// sequencer that runs after reset and on init_start.
// Optional feature macro: SPRAM_PARITY_EN adds one even-parity bit per byte
// and the parity_err output.
module param_sp_ram
  import sp_ram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int RD_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      init_start,
  output logic                      init_busy,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [$clog2(DEPTH)-1:0]  req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [DATA_W/8-1:0]       req_be,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata
`ifdef SPRAM_PARITY_EN
  ,
  output logic                      parity_err
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NB     = DATA_W / 8;
`ifdef SPRAM_PARITY_EN
  localparam int LANE_W = BYTE_W + 1;
`else
  localparam int LANE_W = BYTE_W;
`endif
  localparam int MEM_W  = NB * LANE_W;

  // Byte-wise merge of write data over an old word.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] m;
    m = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) m[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
    return m;
  endfunction

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic                w_ptr_last;
  logic                w_accept;
  logic                w_in_range;

  logic                w_core_en;
  logic                w_core_we;
  logic [NB-1:0]       w_core_be;
  logic [ADDR_W-1:0]   w_core_addr;
  logic [MEM_W-1:0]    w_core_wdata;
  logic [MEM_W-1:0]    w_core_rdata;
  logic [MEM_W-1:0]    w_lane_wdata;

  logic                r_vld_p1;
  logic                r_we_p1;
  logic                r_oor_p1;
  logic [DATA_W-1:0]   r_wdata_p1;
  logic [NB-1:0]       r_be_p1;
  logic [DATA_W-1:0]   r_hold;

  logic [DATA_W-1:0]   w_rd_data;
  logic [DATA_W-1:0]   w_cur;

  assign req_ready  = (r_state == RUN);
  assign init_busy  = (r_state == INIT);
  assign w_accept   = req_valid && req_ready;
  assign w_in_range = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));
  assign w_ptr_last = (r_ptr == ADDR_W'(DEPTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= INIT;
    else        r_state <= w_state_nxt;
  end

  // Next state: sweep ends on the last address; init_start only acts in RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (w_ptr_last) w_state_nxt = RUN;
      RUN:     if (init_start) w_state_nxt = INIT;
      default: w_state_nxt = INIT;
    endcase
  end

  // Clear pointer: advances during the sweep, parked at zero otherwise so a
  // new sweep always starts from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (r_state == INIT) begin
      r_ptr <= w_ptr_last ? '0 : r_ptr + 1'b1;
    end else begin
      r_ptr <= '0;
    end
  end

  // Pack request bytes into storage lanes, adding parity where stored.
  always_comb begin
    w_lane_wdata = '0;
    for (int i = 0; i < NB; i++) begin
`ifdef SPRAM_PARITY_EN
      w_lane_wdata[i*LANE_W +: LANE_W] = {byte_parity(req_wdata[i*BYTE_W +: BYTE_W]),
                                          req_wdata[i*BYTE_W +: BYTE_W]};
`else
      w_lane_wdata[i*LANE_W +: LANE_W] = req_wdata[i*BYTE_W +: BYTE_W];
`endif
    end
  end

  // Core port mux: the sweep owns the array in INIT, requests own it in RUN.
  // Out-of-range requests never touch the array.
  always_comb begin
    w_core_en    = 1'b0;
    w_core_we    = 1'b0;
    w_core_be    = '0;
    w_core_addr  = '0;
    w_core_wdata = '0;
    if (r_state == INIT) begin
      w_core_en    = 1'b1;
      w_core_we    = 1'b1;
      w_core_be    = '1;
      w_core_addr  = r_ptr;
    end else begin
      w_core_en    = w_accept && w_in_range;
      w_core_we    = req_we;
      w_core_be    = req_be;
      w_core_addr  = req_addr;
      w_core_wdata = w_lane_wdata;
    end
  end

  sp_ram_core #(
    .LANE_W (LANE_W),
    .LANES  (NB),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .i_en    (w_core_en),
    .i_we    (w_core_we),
    .i_be    (w_core_be),
    .i_addr  (w_core_addr),
    .i_wdata (w_core_wdata),
    .o_rdata (w_core_rdata)
  );

  // ---- stage p1: response control, lost on reset ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_we_p1  <= 1'b0;
      r_oor_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_we_p1  <= req_we;
        r_oor_p1 <= !w_in_range;
      end
    end
  end

  // Write data and enables kept for the write-first merged response.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wdata_p1 <= req_wdata;
      r_be_p1    <= req_be;
    end
  end

  // Strip parity bits and select the response word per read-during-write mode.
  // An out-of-range write has no old word, so it answers 0 unless the mode
  // keeps the previous response.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NB; i++) begin
      w_rd_data[i*BYTE_W +: BYTE_W] = w_core_rdata[i*LANE_W +: BYTE_W];
    end
    w_cur = w_rd_data;
    if (r_we_p1) begin
      if (RD_MODE == NO_CHANGE)     w_cur = r_hold;
      else if (r_oor_p1)            w_cur = '0;
      else if (RD_MODE == WR_FIRST) w_cur = merge_bytes(w_rd_data, r_wdata_p1, r_be_p1);
      else                          w_cur = w_rd_data;
    end else if (r_oor_p1) begin
      w_cur = '0;
    end
  end

  // Last delivered response word; rsp_rdata shows it between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_hold <= '0;
    else if (r_vld_p1) r_hold <= w_cur;
  end

  assign rsp_valid = r_vld_p1;
  assign rsp_rdata = r_vld_p1 ? w_cur : r_hold;

`ifdef SPRAM_PARITY_EN
  logic w_perr;

  // Any lane with odd weight over {parity, byte} is a mismatch.
  always_comb begin
    w_perr = 1'b0;
    for (int i = 0; i < NB; i++) begin
      w_perr = w_perr | (^w_core_rdata[i*LANE_W +: LANE_W]);
    end
  end

  assign parity_err = r_vld_p1 && !r_oor_p1 && w_perr;
`endif

endmodule

// File: tb/tb_param_sp_ram.sv
// Testbench for param_sp_ram: three instances (one per read-during-write mode)
// share stimulus; a queue of expected responses is consumed by a monitor.
module tb_param_sp_ram;

  localparam int DEPTH = 12;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          init_start;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_be;
  logic [2:0]    rdy;
  logic [2:0]    busy;
  logic [2:0]    vld;
  logic [31:0]   rdat [3];
`ifdef SPRAM_PARITY_EN
  logic [2:0]    perr;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    param_sp_ram #(
      .DATA_W  (32),
      .DEPTH   (DEPTH),
      .RD_MODE (g)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_start (init_start),
      .init_busy  (busy[g]),
      .req_valid  (req_valid),
      .req_ready  (rdy[g]),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .rsp_valid  (vld[g]),
      .rsp_rdata  (rdat[g])
`ifdef SPRAM_PARITY_EN
      ,
      .parity_err (perr[g])
`endif
    );
  end

  typedef struct packed {
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        pe;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [DEPTH];
  logic        corrupt [DEPTH];
  logic [31:0] hold2;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i]     = 32'h0;
      corrupt[i] = 1'b0;
    end
  endtask

  // Reference behaviour of one accepted request, straight from the rules:
  // reads return the word, writes answer old / merged / previous response.
  task automatic model_step(input logic we, input int addr, input logic [31:0] wd,
                            input logic [3:0] be, input logic init);
    exp_t        e;
    logic [31:0] old_w;
    logic [31:0] new_w;
    logic        inr;
    inr   = (addr < DEPTH);
    old_w = inr ? mdl[addr] : 32'h0;
    new_w = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) new_w[8*b +: 8] = wd[8*b +: 8];
    if (!we) begin
      e.r0 = old_w; e.r1 = old_w; e.r2 = old_w;
    end else if (!inr) begin
      e.r0 = 32'h0; e.r1 = 32'h0; e.r2 = hold2;
    end else begin
      e.r0 = old_w; e.r1 = new_w; e.r2 = hold2;
    end
    e.pe  = inr && corrupt[addr];
    hold2 = e.r2;
    exp_q.push_back(e);
    if (we && inr) begin
      mdl[addr] = new_w;
      if (be[0]) corrupt[addr] = 1'b0;
    end
    if (init) model_clear();
  endtask

  task automatic req(input logic we, input int addr, input logic [31:0] wd,
                     input logic [3:0] be, input logic init);
    chk("req_ready", 32'(rdy), 32'h7);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = AW'(addr);
    req_wdata  = wd;
    req_be     = be;
    init_start = init;
    @(posedge clk);
    model_step(we, addr, wd, be, init);
    #1;
    req_valid  = 1'b0;
    init_start = 1'b0;
  endtask

  // Called just after the edge that starts a sweep (or just after reset
  // release): ready must appear exactly after DEPTH more edges.
  task automatic check_sweep(input string nm, input logic poke_init);
    for (int k = 1; k <= DEPTH; k++) begin
      if (poke_init && k == 2) init_start = 1'b1;
      @(posedge clk);
      #1;
      init_start = 1'b0;
      chk({nm, "_ready"}, 32'(rdy),  (k == DEPTH) ? 32'h7 : 32'h0);
      chk({nm, "_busy"},  32'(busy), (k == DEPTH) ? 32'h0 : 32'h7);
    end
  endtask

  // Monitor: every response strobe pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (vld != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rsp_valid", 32'(vld), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(vld), 32'h7);
        chk("rdata_rd_first", rdat[0], e.r0);
        chk("rdata_wr_first", rdat[1], e.r1);
        chk("rdata_no_change", rdat[2], e.r2);
`ifdef SPRAM_PARITY_EN
        chk("parity_err", 32'(perr), e.pe ? 32'h7 : 32'h0);
`endif
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    init_start = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    hold2      = 32'h0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy),  32'h0);
    chk("rst_busy",  32'(busy), 32'h7);
    chk("rst_valid", 32'(vld),  32'h0);
    chk("rst_rdata0", rdat[0], 32'h0);
    chk("rst_rdata2", rdat[2], 32'h0);
    rst_n = 1'b1;
    check_sweep("post_reset", 1'b0);

    // All locations cleared.
    for (int a = 0; a < DEPTH; a++) req(1'b0, a, 32'h0, 4'h0, 1'b0);

    // Directed: full write, partial write, read-during-write modes.
    req(1'b1, 3, 32'hDEADBEEF, 4'b1111, 1'b0);
    req(1'b0, 3, 32'h0, 4'h0, 1'b0);
    req(1'b1, 3, 32'h11223344, 4'b0101, 1'b0);
    req(1'b0, 3, 32'h0, 4'h0, 1'b0);
    req(1'b1, 4, 32'h12345678, 4'b1111, 1'b0);
    req(1'b0, 3, 32'h0, 4'h0, 1'b0);
    req(1'b1, 4, 32'hCAFEF00D, 4'b1111, 1'b0);
    req(1'b0, 4, 32'h0, 4'h0, 1'b0);
    // No-op write, out-of-range read and write, boundary addresses.
    req(1'b1, 4, 32'h55555555, 4'b0000, 1'b0);
    req(1'b0, 4, 32'h0, 4'h0, 1'b0);
    req(1'b0, 13, 32'h0, 4'h0, 1'b0);
    req(1'b1, 14, 32'hFFFFFFFF, 4'b1111, 1'b0);
    req(1'b1, DEPTH-1, 32'hA1B2C3D4, 4'b1111, 1'b0);
    req(1'b0, DEPTH-1, 32'h0, 4'h0, 1'b0);
    req(1'b0, 0, 32'h0, 4'h0, 1'b0);

`ifdef SPRAM_PARITY_EN
    req(1'b1, 7, 32'h0F0F0F0F, 4'b1111, 1'b0);
    g_dut[0].u_dut.u_core.r_mem[7][0] = ~g_dut[0].u_dut.u_core.r_mem[7][0];
    g_dut[1].u_dut.u_core.r_mem[7][0] = ~g_dut[1].u_dut.u_core.r_mem[7][0];
    g_dut[2].u_dut.u_core.r_mem[7][0] = ~g_dut[2].u_dut.u_core.r_mem[7][0];
    mdl[7][0]  = ~mdl[7][0];
    corrupt[7] = 1'b1;
    req(1'b0, 7, 32'h0, 4'h0, 1'b0);
    req(1'b0, 6, 32'h0, 4'h0, 1'b0);
    req(1'b1, 7, 32'h01020304, 4'b0001, 1'b0);
    req(1'b0, 7, 32'h0, 4'h0, 1'b0);
`endif

    // Randomised traffic with idle gaps.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        req(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
            4'($urandom_range(0, 15)), 1'b0);
      end
    end

    // Clear command with a concurrent write; a second pulse mid-sweep is ignored.
    req(1'b1, 5, 32'hA5A5A5A5, 4'b1111, 1'b1);
    chk("init_ready", 32'(rdy),  32'h0);
    chk("init_busy",  32'(busy), 32'h7);
    check_sweep("reinit", 1'b1);
    req(1'b0, 5, 32'h0, 4'h0, 1'b0);
    req(1'b1, 2, 32'h87654321, 4'b1111, 1'b0);
    req(1'b0, 2, 32'h0, 4'h0, 1'b0);

    // Reset right after a request is accepted: its response is lost.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = AW'(2);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    model_clear();
    hold2 = 32'h0;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(vld),  32'h0);
    chk("midrst_rdata", rdat[2],   32'h0);
    chk("midrst_busy",  32'(busy), 32'h7);
    rst_n = 1'b1;
    check_sweep("midrst", 1'b0);
    req(1'b0, 2, 32'h0, 4'h0, 1'b0);
    req(1'b1, 2, 32'h0BADF00D, 4'b1010, 1'b0);
    req(1'b0, 2, 32'h0, 4'h0, 1'b0);

    // Drain outstanding responses within a bounded window.
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
